// File: rtl/crc_stream_engine_pkg.sv
// Shared types and constants for the streaming CRC engine.
// Holds the FSM state encoding, standard CRC parameter sets and a byte bit-reverse helper.
// Contains no logic of its own and no latency or flow control.
package crc_stream_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } crc_state_t;

    // CRC-8/SMBUS
    localparam logic [7:0]  CRC8_SMBUS_POLY           = 8'h07;
    localparam logic [7:0]  CRC8_SMBUS_INIT           = 8'h00;
    localparam logic [7:0]  CRC8_SMBUS_XOROUT         = 8'h00;
    localparam logic [7:0]  CRC8_SMBUS_RESIDUE        = 8'h00;

    // CRC-16/CCITT-FALSE
    localparam logic [15:0] CRC16_CCITT_FALSE_POLY    = 16'h1021;
    localparam logic [15:0] CRC16_CCITT_FALSE_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC16_CCITT_FALSE_XOROUT  = 16'h0000;
    localparam logic [15:0] CRC16_CCITT_FALSE_RESIDUE = 16'h0000;

    // CRC-32 (Ethernet); residue expressed in output (reflected) bit order
    localparam logic [31:0] CRC32_ETH_POLY            = 32'h04C11DB7;
    localparam logic [31:0] CRC32_ETH_INIT            = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_ETH_XOROUT          = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_ETH_RESIDUE         = 32'hDEBB20E3;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

endpackage

// File: rtl/crc_byte_step.sv
// One-byte MSB-first LFSR update of a CRC register, optional input byte reflection.
// Purely combinational, zero latency.
// No flow control; the instantiating stage owns the handshake.
// Ports: crc_in (current register), data (one byte), crc_out (register after 8 shifts).
module crc_byte_step
    import crc_stream_engine_pkg::*;
#(
    parameter int               CRC_W = 8,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(8'h07),
    parameter bit               REFIN = 1'b0
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic [7:0]       data,
    output logic [CRC_W-1:0] crc_out
);

    logic [7:0]       d;
    logic [CRC_W-1:0] c;

    always_comb begin
        d = REFIN ? rev8(data) : data;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c << 1) ^ ((c[CRC_W-1] ^ d[7-i]) ? POLY : '0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker: one result per SOF..EOF frame of DATA_W-bit beats.
// Latency: out_valid rises the cycle after the EOF beat is accepted; one bubble per frame.
// Backpressure: in_ready drops while a result waits for out_ready; all outputs registered.
// Ports: clk/rst; in_valid/in_ready/in_data/in_sof/in_eof/in_bytes beat input;
//        out_valid/out_ready/out_crc/out_ok result; frame_err pulse for a beat without SOF in IDLE.
module crc_stream_engine
    import crc_stream_engine_pkg::*;
#(
    parameter int               CRC_W   = 8,
    parameter int               DATA_W  = 8,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(8'h07),
    parameter logic [CRC_W-1:0] INIT    = CRC_W'(8'hFF),
    parameter bit               REFIN   = 1'b0,
    parameter bit               REFOUT  = 1'b0,
    parameter logic [CRC_W-1:0] XOROUT  = CRC_W'(8'h00),
    parameter logic [CRC_W-1:0] RESIDUE = CRC_W'(8'h00),
    localparam int              NB      = DATA_W / 8,
    localparam int              LBW     = $clog2(NB) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_eof,
    input  logic [LBW-1:0]    in_bytes,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  out_crc,
    output logic              out_ok,
    output logic              frame_err
);

    crc_state_t               state;
    logic [CRC_W-1:0]         crc_q;
    logic [NB:0][CRC_W-1:0]   chain;
    logic [CRC_W-1:0]         next_crc;
    logic [CRC_W-1:0]         next_out;

    // SOF always restarts from INIT, which also covers a SOF arriving mid-frame.
    assign chain[0] = in_sof ? INIT : crc_q;

    for (genvar k = 0; k < NB; k++) begin : g_step
        crc_byte_step #(
            .CRC_W (CRC_W),
            .POLY  (POLY),
            .REFIN (REFIN)
        ) u_step (
            .crc_in  (chain[k]),
            .data    (in_data[DATA_W-1-8*k -: 8]),
            .crc_out (chain[k+1])
        );
    end

    // Partial EOF beat taps the chain after in_bytes steps; 0 or >NB falls
    // through to the full-beat result.
    always_comb begin
        next_crc = chain[NB];
        if (in_eof) begin
            for (int k = 1; k < NB; k++) begin
                if (in_bytes == LBW'(k)) next_crc = chain[k];
            end
        end
    end

    // The residue is compared in output bit order (after REFOUT, before
    // XOROUT), so reflected algorithms use their customary published residue.
    always_comb begin
        next_out = next_crc;
        if (REFOUT) begin
            for (int i = 0; i < CRC_W; i++) next_out[i] = next_crc[CRC_W-1-i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            crc_q     <= INIT;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_crc   <= '0;
            out_ok    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                ST_IDLE, ST_ACCUM: begin
                    if (in_valid && in_ready) begin
                        if (state == ST_IDLE && !in_sof) begin
                            frame_err <= 1'b1;
                        end else if (in_eof) begin
                            crc_q     <= next_crc;
                            state     <= ST_DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_crc   <= next_out ^ XOROUT;
                            out_ok    <= (next_out == RESIDUE);
                        end else begin
                            crc_q <= next_crc;
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        crc_q     <= INIT;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    crc_q     <= INIT;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
module tb_crc_stream_engine;
    import crc_stream_engine_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // CRC-8/SMBUS, 8-bit beats
    logic        v8 = 1'b0, sof8 = 1'b0, eof8 = 1'b0, b8 = 1'b0, ordy8 = 1'b1;
    logic [7:0]  d8 = '0;
    logic        rdy8, ov8, ok8, fe8;
    logic [7:0]  crc8;

    // 32-bit beats shared by the CRC-16 and CRC-32 instances
    logic        v32 = 1'b0, sof32 = 1'b0, eof32 = 1'b0, ordy32 = 1'b1;
    logic [31:0] d32 = '0;
    logic [2:0]  b32 = '0;
    logic        rdy16, ov16, ok16, fe16;
    logic [15:0] crc16;
    logic        rdyw, ovw, okw, few;
    logic [31:0] crcw;

    crc_stream_engine #(
        .CRC_W(8), .DATA_W(8), .POLY(CRC8_SMBUS_POLY), .INIT(CRC8_SMBUS_INIT),
        .REFIN(1'b0), .REFOUT(1'b0), .XOROUT(CRC8_SMBUS_XOROUT), .RESIDUE(CRC8_SMBUS_RESIDUE)
    ) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_data(d8),
        .in_sof(sof8), .in_eof(eof8), .in_bytes(b8), .out_valid(ov8),
        .out_ready(ordy8), .out_crc(crc8), .out_ok(ok8), .frame_err(fe8)
    );

    crc_stream_engine #(
        .CRC_W(16), .DATA_W(32), .POLY(CRC16_CCITT_FALSE_POLY), .INIT(CRC16_CCITT_FALSE_INIT),
        .REFIN(1'b0), .REFOUT(1'b0), .XOROUT(CRC16_CCITT_FALSE_XOROUT),
        .RESIDUE(CRC16_CCITT_FALSE_RESIDUE)
    ) dut16 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy16), .in_data(d32),
        .in_sof(sof32), .in_eof(eof32), .in_bytes(b32), .out_valid(ov16),
        .out_ready(ordy32), .out_crc(crc16), .out_ok(ok16), .frame_err(fe16)
    );

    crc_stream_engine #(
        .CRC_W(32), .DATA_W(32), .POLY(CRC32_ETH_POLY), .INIT(CRC32_ETH_INIT),
        .REFIN(1'b1), .REFOUT(1'b1), .XOROUT(CRC32_ETH_XOROUT), .RESIDUE(CRC32_ETH_RESIDUE)
    ) dut32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdyw), .in_data(d32),
        .in_sof(sof32), .in_eof(eof32), .in_bytes(b32), .out_valid(ovw),
        .out_ready(ordy32), .out_crc(crcw), .out_ok(okw), .frame_err(few)
    );

    // Stimulus helpers: one beat each, returning #1 after the accepting edge.
    task automatic put8(input logic [7:0] d, input logic sof, input logic eof);
        v8 = 1'b1; d8 = d; sof8 = sof; eof8 = eof;
        @(posedge clk); #1;
        v8 = 1'b0; sof8 = 1'b0; eof8 = 1'b0;
    endtask

    task automatic put32(input logic [31:0] d, input logic sof, input logic eof,
                         input logic [2:0] nbytes);
        v32 = 1'b1; d32 = d; sof32 = sof; eof32 = eof; b32 = nbytes;
        @(posedge clk); #1;
        v32 = 1'b0; sof32 = 1'b0; eof32 = 1'b0; b32 = '0;
    endtask

    // "123456789", one byte per beat
    task automatic frame8();
        for (int i = 0; i < 9; i++) put8(8'(32'h31 + i), i == 0, i == 8);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (rdy8 !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready8: got %b want 1", rdy8); end
        n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid8: got %b want 0", ov8); end
        n_checks++; if (crc8 !== 8'h00) begin n_fail++; $display("FAIL rst_out_crc8: got %h want 00", crc8); end
        n_checks++; if (ok8 !== 1'b0) begin n_fail++; $display("FAIL rst_out_ok8: got %b want 0", ok8); end
        n_checks++; if (fe8 !== 1'b0) begin n_fail++; $display("FAIL rst_frame_err8: got %b want 0", fe8); end
        n_checks++; if ({rdy16, ov16, ok16, fe16} !== 4'b1000) begin n_fail++; $display("FAIL rst_flags16: got %b want 1000", {rdy16, ov16, ok16, fe16}); end
        n_checks++; if ({rdyw, ovw, okw, few} !== 4'b1000) begin n_fail++; $display("FAIL rst_flags32: got %b want 1000", {rdyw, ovw, okw, few}); end
        n_checks++; if (crcw !== 32'h0) begin n_fail++; $display("FAIL rst_out_crc32: got %h want 00000000", crcw); end
        rst = 1'b0;
    endtask

    task automatic test_crc8();
        frame8();
        n_checks++; if (ov8 !== 1'b1) begin n_fail++; $display("FAIL crc8_latency: out_valid got %b want 1", ov8); end
        n_checks++; if (crc8 !== 8'hF4) begin n_fail++; $display("FAIL crc8_value: got %h want f4", crc8); end
        n_checks++; if (ok8 !== 1'b0) begin n_fail++; $display("FAIL crc8_ok: got %b want 0", ok8); end
        n_checks++; if (rdy8 !== 1'b0) begin n_fail++; $display("FAIL crc8_done_ready: got %b want 0", rdy8); end
        tick();
        n_checks++; if ({ov8, rdy8} !== 2'b01) begin n_fail++; $display("FAIL crc8_consume: valid/ready got %b want 01", {ov8, rdy8}); end
    endtask

    task automatic test_wide();
        // "123456789", in_bytes=1 on non-EOF beats must be ignored, junk in unused EOF bytes
        put32(32'h31323334, 1'b1, 1'b0, 3'd1);
        put32(32'h35363738, 1'b0, 1'b0, 3'd1);
        put32(32'h39FFFFFF, 1'b0, 1'b1, 3'd1);
        n_checks++; if ({ov16, crc16, ok16} !== {1'b1, 16'h29B1, 1'b0}) begin n_fail++; $display("FAIL crc16_check: valid/crc/ok got %b/%h/%b want 1/29b1/0", ov16, crc16, ok16); end
        n_checks++; if ({ovw, crcw, okw} !== {1'b1, 32'hCBF43926, 1'b0}) begin n_fail++; $display("FAIL crc32_check: valid/crc/ok got %b/%h/%b want 1/cbf43926/0", ovw, crcw, okw); end
        tick();
        n_checks++; if ({ov16, rdy16, ovw, rdyw} !== 4'b0101) begin n_fail++; $display("FAIL wide_consume: got %b want 0101", {ov16, rdy16, ovw, rdyw}); end

        // message + its CRC-16 + one zero byte leaves a zero register; in_bytes=0 means full beat
        put32(32'h31323334, 1'b1, 1'b0, 3'd0);
        put32(32'h35363738, 1'b0, 1'b0, 3'd0);
        put32(32'h3929B100, 1'b0, 1'b1, 3'd0);
        n_checks++; if ({ov16, crc16, ok16} !== {1'b1, 16'h0000, 1'b1}) begin n_fail++; $display("FAIL crc16_bytes0: valid/crc/ok got %b/%h/%b want 1/0000/1", ov16, crc16, ok16); end
        tick();

        // in_bytes above NB also means full beat
        put32(32'h31323334, 1'b1, 1'b0, 3'd0);
        put32(32'h35363738, 1'b0, 1'b0, 3'd0);
        put32(32'h3929B100, 1'b0, 1'b1, 3'd7);
        n_checks++; if ({ov16, crc16, ok16} !== {1'b1, 16'h0000, 1'b1}) begin n_fail++; $display("FAIL crc16_bytes7: valid/crc/ok got %b/%h/%b want 1/0000/1", ov16, crc16, ok16); end
        tick();

        // CRC-32 residue: data followed by CRC bytes 26 39 F4 CB
        put32(32'h31323334, 1'b1, 1'b0, 3'd0);
        put32(32'h35363738, 1'b0, 1'b0, 3'd0);
        put32(32'h392639F4, 1'b0, 1'b0, 3'd0);
        put32(32'hCB000000, 1'b0, 1'b1, 3'd1);
        n_checks++; if ({ovw, okw} !== 2'b11) begin n_fail++; $display("FAIL crc32_residue_ok: valid/ok got %b want 11", {ovw, okw}); end
        n_checks++; if (crcw !== 32'h2144DF1C) begin n_fail++; $display("FAIL crc32_residue_crc: got %h want 2144df1c", crcw); end
        tick();
    endtask

    task automatic test_stall();
        ordy8 = 1'b0;
        frame8();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if ({ov8, crc8, rdy8} !== {1'b1, 8'hF4, 1'b0}) begin n_fail++; $display("FAIL stall_hold%0d: valid/crc/ready got %b/%h/%b want 1/f4/0", i, ov8, crc8, rdy8); end
            tick();
        end
        ordy8 = 1'b1;
        tick();
        n_checks++; if ({ov8, rdy8} !== 2'b01) begin n_fail++; $display("FAIL stall_release: valid/ready got %b want 01", {ov8, rdy8}); end
        frame8();
        n_checks++; if ({ov8, crc8} !== {1'b1, 8'hF4}) begin n_fail++; $display("FAIL stall_next: valid/crc got %b/%h want 1/f4", ov8, crc8); end
        tick();
    endtask

    task automatic test_frame_err();
        put8(8'h55, 1'b0, 1'b0);
        n_checks++; if ({fe8, ov8} !== 2'b10) begin n_fail++; $display("FAIL ferr_pulse: err/valid got %b want 10", {fe8, ov8}); end
        tick();
        n_checks++; if ({fe8, ov8, rdy8} !== 3'b001) begin n_fail++; $display("FAIL ferr_clear: err/valid/ready got %b want 001", {fe8, ov8, rdy8}); end
    endtask

    task automatic test_sof_restart();
        put8(8'hAA, 1'b1, 1'b0);
        put8(8'h55, 1'b0, 1'b0);
        frame8();
        n_checks++; if ({ov8, crc8, fe8} !== {1'b1, 8'hF4, 1'b0}) begin n_fail++; $display("FAIL sof_restart: valid/crc/err got %b/%h/%b want 1/f4/0", ov8, crc8, fe8); end
        tick();
    endtask

    task automatic test_reset_mid();
        put8(8'h31, 1'b1, 1'b0);
        put8(8'h32, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if ({ov8, rdy8} !== 2'b01) begin n_fail++; $display("FAIL rst_mid_frame: valid/ready got %b want 01", {ov8, rdy8}); end
        frame8();
        n_checks++; if ({ov8, crc8} !== {1'b1, 8'hF4}) begin n_fail++; $display("FAIL rst_mid_next: valid/crc got %b/%h want 1/f4", ov8, crc8); end
        tick();

        ordy8 = 1'b0;
        frame8();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if ({ov8, rdy8} !== 2'b01) begin n_fail++; $display("FAIL rst_in_done: valid/ready got %b want 01", {ov8, rdy8}); end
        ordy8 = 1'b1;
        frame8();
        n_checks++; if ({ov8, crc8} !== {1'b1, 8'hF4}) begin n_fail++; $display("FAIL rst_done_next: valid/crc got %b/%h want 1/f4", ov8, crc8); end
        tick();
    endtask

    initial begin
        test_reset();
        test_crc8();
        test_wide();
        test_stall();
        test_frame_err();
        test_sof_restart();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

endmodule
